// File: rtl/player_motion_ctrl_if.sv
// Video-side bundle of the player motion controller: frame sync and object size in, committed position out.
// master = motion controller (drives position), slave = video controller (drives VS and object size).
interface player_motion_ctrl_if;
  logic       VS;
  logic [9:0] player_objWidth;
  logic [9:0] player_objHeight;
  logic [9:0] player_hStartPos;
  logic [9:0] player_vStartPos;
  logic       pos_update;

  modport master (
    input  VS,
    input  player_objWidth,
    input  player_objHeight,
    output player_hStartPos,
    output player_vStartPos,
    output pos_update
  );

  modport slave (
    output VS,
    output player_objWidth,
    output player_objHeight,
    input  player_hStartPos,
    input  player_vStartPos,
    input  pos_update
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// Debounced buttons move the player object once per frame (VS falling edge), clamped fully on screen.
// Latency: position and pos_update change 2 cycles after the edge that samples the tick.
// Backpressure: none; ticks arriving while a frame update is in flight are dropped.
module player_motion_ctrl #(
  parameter int STEP      = 2,
  parameter int DB_CYCLES = 100000,
  parameter int H_MAX     = 640,
  parameter int V_MAX     = 480,
  parameter int H_INIT    = 320,
  parameter int V_INIT    = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btns,
  input  logic       recenter,
  input  logic [3:0] blocked,
  output logic [3:0] btn_db,
  player_motion_ctrl_if.master video
);

  localparam int              CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [10:0]     STEP_W   = 11'(STEP);
  localparam logic [10:0]     H_MAX_W  = 11'(H_MAX);
  localparam logic [10:0]     V_MAX_W  = 11'(V_MAX);
  localparam logic [10:0]     H_INIT_W = 11'(H_INIT);
  localparam logic [10:0]     V_INIT_W = 11'(V_INIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic             calcEn;
  logic             commitEn;
  logic [CNT_W-1:0] dbCnt [4];
  logic             vsQ;
  logic             vsSeen;
  logic             tick;
  logic [10:0]      hLim;
  logic [10:0]      vLim;
  logic [10:0]      candH;
  logic [10:0]      candV;
  logic [10:0]      nextH;
  logic [10:0]      nextV;

  // A raw level must differ from the debounced level for DB_CYCLES consecutive edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db <= '0;
      for (int i = 0; i < 4; i++) dbCnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btns[i] != btn_db[i]) begin
          if (dbCnt[i] == CNT_LAST) begin
            btn_db[i] <= btns[i];
            dbCnt[i]  <= '0;
          end else begin
            dbCnt[i] <= dbCnt[i] + CNT_W'(1);
          end
        end else begin
          dbCnt[i] <= '0;
        end
      end
    end
  end

  // vsSeen keeps a VS held low across reset release from looking like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsQ    <= 1'b1;
      vsSeen <= 1'b0;
    end else begin
      vsQ <= video.VS;
      if (video.VS) vsSeen <= 1'b1;
    end
  end

  assign tick = vsQ & ~video.VS & vsSeen;

  function automatic logic [10:0] moveAxis(
    input logic [10:0] pos,
    input logic        plusReq,
    input logic        minusReq,
    input logic        plusBlk,
    input logic        minusBlk,
    input logic [10:0] lim
  );
    logic [10:0] cand;
    cand = pos;
    if (minusReq && !plusReq && !minusBlk) begin
      cand = (pos < STEP_W) ? 11'd0 : pos - STEP_W;
    end else if (plusReq && !minusReq && !plusBlk) begin
      cand = ((pos + STEP_W) > lim) ? lim : pos + STEP_W;
    end
    // Also pulls the object back on screen if its size grew while parked at the edge.
    if (cand > lim) cand = lim;
    return cand;
  endfunction

  always_comb begin
    hLim = ({1'b0, video.player_objWidth} >= H_MAX_W) ? 11'd0
         : H_MAX_W - {1'b0, video.player_objWidth};
    vLim = ({1'b0, video.player_objHeight} >= V_MAX_W) ? 11'd0
         : V_MAX_W - {1'b0, video.player_objHeight};
  end

  // Screen y grows downward: down is the plus direction, up the minus.
  always_comb begin
    candH = moveAxis({1'b0, video.player_hStartPos}, btn_db[3], btn_db[2],
                     blocked[3], blocked[2], hLim);
    candV = moveAxis({1'b0, video.player_vStartPos}, btn_db[1], btn_db[0],
                     blocked[1], blocked[0], vLim);
    if (recenter) begin
      candH = (H_INIT_W > hLim) ? hLim : H_INIT_W;
      candV = (V_INIT_W > vLim) ? vLim : V_INIT_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    calcEn    = 1'b0;
    commitEn  = 1'b0;
    case (state)
      IDLE: begin
        if (tick) stateNext = CALC;
      end
      CALC: begin
        calcEn    = 1'b1;
        stateNext = COMMIT;
      end
      COMMIT: begin
        commitEn  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nextH                  <= H_INIT_W;
      nextV                  <= V_INIT_W;
      video.player_hStartPos <= 10'(H_INIT);
      video.player_vStartPos <= 10'(V_INIT);
      video.pos_update       <= 1'b0;
    end else begin
      video.pos_update <= 1'b0;
      if (calcEn) begin
        nextH <= candH;
        nextV <= candV;
      end
      if (commitEn) begin
        video.player_hStartPos <= nextH[9:0];
        video.player_vStartPos <= nextV[9:0];
        video.pos_update       <= (nextH != {1'b0, video.player_hStartPos}) ||
                                  (nextV != {1'b0, video.player_vStartPos});
      end
    end
  end

  // The frame FSM takes three cycles per pass, so pos_update can never be two cycles wide.
  a_pos_update_pulse: assert property (@(posedge clk) disable iff (rst)
    video.pos_update |=> !video.pos_update);

  a_state_legal: assert property (@(posedge clk) disable iff (rst)
    state != 2'd3);

endmodule
